// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter with valid/ready load and gapless streaming.
// Optional even parity bit after the data bits: define PISO_TX_PARITY_EN.
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             serial_out,
  output logic             shift_en,
  output logic             busy,
  output logic             done
);

`ifdef PISO_TX_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [N-1:0]     shreg;
  logic [N-1:0]     frame;
  logic [WIDTH-1:0] ordered;
  logic             last;
  logic             accept;

  assign last       = (state == SHIFT) && (cnt == LAST);
  assign load_ready = (state == IDLE) || last;
  assign accept     = load_valid && load_ready;

  // frame[N-1] is always the first bit on the wire
  always_comb begin
    ordered = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST)
        ordered[i] = data_in[i];
      else
        ordered[i] = data_in[WIDTH-1-i];
    end
`ifdef PISO_TX_PARITY_EN
    frame = {ordered, ^data_in};
`else
    frame = ordered;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      serial_out <= 1'b0;
      shift_en   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (accept) begin
      state      <= SHIFT;
      cnt        <= '0;
      serial_out <= frame[N-1];
      shreg      <= {frame[N-2:0], 1'b0};
      shift_en   <= 1'b1;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else if (last) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      serial_out <= 1'b0;
      shift_en   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (state == SHIFT) begin
      cnt        <= cnt + 1'b1;
      serial_out <= shreg[N-1];
      shreg      <= {shreg[N-2:0], 1'b0};
      done       <= ((cnt + 1'b1) == LAST);
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: both bit orders driven in parallel against
// a queue-of-pending-bits reference model, directed cases then random.
module tb_piso_shift_tx;

`ifdef PISO_TX_PARITY_EN
  localparam int N = 9;
`else
  localparam int N = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] data_in = '0;

  logic rdy_m, so_m, se_m, busy_m, done_m;
  logic rdy_l, so_l, se_l, busy_l, done_l;

  int tests = 0;
  int fails = 0;

  bit q_m[$];
  bit q_l[$];

  logic [7:0] rx = '0;

  always #5 clk = ~clk;

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid),
    .load_ready(rdy_m), .data_in(data_in), .serial_out(so_m),
    .shift_en(se_m), .busy(busy_m), .done(done_m)
  );

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid),
    .load_ready(rdy_l), .data_in(data_in), .serial_out(so_l),
    .shift_en(se_l), .busy(busy_l), .done(done_l)
  );

  // stand-in for the shift_reg receiver, MSB-first into bit 0
  always @(posedge clk)
    if (se_m) rx <= {rx[6:0], so_m};

  task automatic chk(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_q(input string pfx, ref bit q[$],
                       input logic so, input logic se, input logic bz,
                       input logic dn, input logic rd);
    int n;
    n = q.size();
    chk({pfx, ".serial_out"}, so, (n > 0) ? logic'(q[0]) : 1'b0);
    chk({pfx, ".shift_en"}, se, n > 0);
    chk({pfx, ".busy"}, bz, n > 0);
    chk({pfx, ".done"}, dn, n == 1);
    chk({pfx, ".load_ready"}, rd, n <= 1);
  endtask

  task automatic push_frame(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) q_m.push_back(d[i]);
    for (int i = 0; i < 8; i++) q_l.push_back(d[i]);
`ifdef PISO_TX_PARITY_EN
    q_m.push_back(^d);
    q_l.push_back(^d);
`endif
  endtask

  // one clock: drive, advance model on the edge, check #1 later
  task automatic step(input logic r, input logic lv, input logic [7:0] d);
    bit acc;
    rst_n = r;
    load_valid = lv;
    data_in = d;
    acc = r && lv && (q_m.size() <= 1);
    @(posedge clk);
    if (!r) begin
      q_m.delete();
      q_l.delete();
    end else begin
      if (q_m.size() > 0) void'(q_m.pop_front());
      if (q_l.size() > 0) void'(q_l.pop_front());
      if (acc) push_frame(d);
    end
    #1;
    chk_q("msb", q_m, so_m, se_m, busy_m, done_m, rdy_m);
    chk_q("lsb", q_l, so_l, se_l, busy_l, done_l, rdy_l);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("reset.serial_out", so_m, 1'b0);
    chk("reset.shift_en", se_m, 1'b0);
    chk("reset.busy", busy_m, 1'b0);
    chk("reset.done", done_m, 1'b0);
    chk("reset.load_ready", rdy_m, 1'b1);

    // single word
    step(1'b1, 1'b1, 8'hA5);
    idle(N + 1);

    // back-to-back: held valid, new word on the last bit
    for (int i = 0; i < N; i++) step(1'b1, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 8'h00);
    idle(N + 1);

    // data_in changes while busy are ignored
    step(1'b1, 1'b1, 8'hC3);
    step(1'b1, 1'b0, 8'hC3);
    step(1'b1, 1'b0, 8'hC3);
    for (int i = 0; i < N - 2; i++) step(1'b1, 1'b1, 8'h3C);
    idle(N + 1);

    // reset mid-frame
    step(1'b1, 1'b1, 8'hF0);
    idle(2);
    step(1'b0, 1'b0, 8'h00);
    chk("midrst.shift_en", se_m, 1'b0);
    chk("midrst.load_ready", rdy_m, 1'b1);
    idle(3);

    // LSB-first word and reset winning over load
    step(1'b1, 1'b1, 8'h01);
    chk("lsb01.first_bit", so_l, 1'b1);
    idle(N + 1);
    step(1'b0, 1'b1, 8'hAA);
    chk("rstload.shift_en", se_m, 1'b0);
    idle(2);

`ifndef PISO_TX_PARITY_EN
    step(1'b1, 1'b1, 8'h5A);
    idle(N);
    tests++;
    assert (rx === 8'h5A) else begin
      fails++;
      $error("FAIL loopback observed=%h expected=%h", rx, 8'h5A);
    end
`else
    step(1'b1, 1'b1, 8'h07);
    idle(N - 1);
    chk("parity.bit9", so_m, 1'b1);
    chk("parity.done", done_m, 1'b1);
    idle(2);
`endif

    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 49) != 0), logic'($urandom_range(0, 1)),
           8'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
Parallel-in, serial-out transmitter, the sending end of the serial bit stream that the shift_reg receiver captures. Accepts a WIDTH-bit word through a valid/ready handshake and drives it one bit per clock on serial_out. shift_en is asserted for every valid bit, so the output pair connects directly to shift_reg's data_in and shift_en inputs. Back-to-back words stream with no idle gap.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = bit WIDTH-1 transmitted first; 0 = bit 0 transmitted first.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
load_valid  input  1  sender offers a word on data_in.
load_ready  output  1  block can accept a word this cycle.
data_in  input  WIDTH  parallel word; captured when load_valid && load_ready.
serial_out  output  1  current serial bit.
shift_en  output  1  serial_out carries a valid bit this cycle.
busy  output  1  a frame is in progress.
done  output  1  one-cycle pulse during the last bit of a frame.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, shift register=0, bit counter=0. After reset: serial_out=0, shift_en=0, busy=0, done=0, load_ready=1.
- Reset is synchronous only. A reset mid-frame discards the word, and the outputs above are valid on the cycle after that edge.
- All outputs are registered except load_ready, which is decoded from state and counter.
- FSM states are IDLE and SHIFT.
- IDLE:
  - load_ready=1, shift_en=0, serial_out=0.
  - On an edge with load_valid=1, capture data_in, clear the counter and go to SHIFT.
- SHIFT:
  - The first bit appears on serial_out the cycle after acceptance (latency 1).
  - shift_en=1 and busy=1 for exactly N cycles, where N=WIDTH (N=WIDTH+1 with the optional feature).
  - Bit order follows MSB_FIRST.
  - The counter increments every SHIFT cycle and never wraps past N-1.
- Last-bit cycle (counter=N-1):
  - done=1 and load_ready=1.
  - If load_valid=1 on that edge, the new word is captured, the counter resets to 0 and the FSM stays in SHIFT. The first bit of the new word follows with no gap, so shift_en stays high.
  - Otherwise the FSM returns to IDLE, with shift_en=0 and busy=0 on the next cycle.
- During SHIFT, except the last-bit cycle: load_ready=0. load_valid is ignored, and the sender must hold data_in and load_valid until accepted.
- data_in changes while not being accepted have no effect on the frame in flight.
- rst_n=0 coinciding with load_valid=1: reset wins and the word is not captured.

Optional Feature:
Macro PISO_TX_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra bit is sent, equal to the XOR of the captured word (even parity).
  - shift_en stays high for WIDTH+1 cycles.
  - done and the load_ready overlap move to the parity cycle.
- Undefined:
  - No parity logic is compiled in.
  - Frames are exactly WIDTH bits.

Test Plan:
- Single word, WIDTH=8, MSB_FIRST=1: reset, then load 0xA5 with one load_valid pulse -> starting 1 cycle later, serial_out=1,0,1,0,0,1,0,1 over 8 cycles with shift_en=1 and busy=1; done=1 on the 8th bit; next cycle shift_en=0, busy=0, load_ready=1.
- Back-to-back: hold load_valid=1 with 0xFF, then present 0x00 when load_ready rises on the last bit -> 16 contiguous shift_en cycles, 8 ones then 8 zeros, two done pulses 8 cycles apart.
- Busy ignore: during bit 3 of 0xC3, change data_in to 0x3C with load_valid=1 -> load_ready=0 until the last bit; 0xC3 is sent intact, then 0x3C follows immediately.
- Reset mid-frame: drive rst_n=0 for one edge after 3 bits of 0xF0 -> next cycle serial_out=0, shift_en=0, busy=0, done=0, load_ready=1; no further bits are emitted.
- Bit order, MSB_FIRST=0: load 0x01 -> serial_out=1 on the first bit, then seven 0s.
- Loopback and parity:
  - Connect serial_out to shift_reg data_in and shift_en to shift_en, then send 0x5A -> shift_reg data_out=0x5A one cycle after done.
  - With PISO_TX_PARITY_EN defined, load 0x07 -> 9th bit=1, shift_en high for 9 cycles.
